stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with a valid/ready handshake on every input and on the output.
- Selection mode is chosen at run time: external select (mode 0) or fair round-robin arbitration among valid inputs (mode 1).
- Output is registered (one-entry output stage, 1-cycle latency) and carries the index of the channel that produced each word.
- Successor to the team's combinational 2:1 mux; used wherever several producers share one consumer.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel in bits; legal range 1..64.
- SELW, $clog2(N), width of the select and channel-index fields; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = external select, 1 = round-robin.
- sel  input  SELW  channel select, used only in mode 0.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SELW  channel index of out_data (registered).

Behaviour:
- Reset: asynchronous on the falling edge of rst_n, released synchronously by design practice.
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer last=N-1, so channel 0 has first priority.
- load_en = !out_valid || out_ready. The output register may accept a new word only when load_en=1.
- Candidate channel c is computed each cycle:
  - Mode 0: c=sel. If sel>=N, there is no candidate.
  - Mode 1: c is the first i with in_valid[i]=1, searching last+1, last+2, ... modulo N. If no input is valid, there is no candidate.
- in_ready[i] = load_en && candidate exists && (i==c). At most one bit of in_ready is set.
  - In mode 0, in_ready does not depend on in_valid.
  - In mode 1, in_ready depends on in_valid. Upstream in_valid must not depend on in_ready.
- Input transfer on channel i: in_valid[i] && in_ready[i] at the rising edge. At that edge: out_data <= channel c data, out_chan <= c, out_valid <= 1.
- If load_en=1 and no transfer occurs: out_valid <= 0. out_data and out_chan hold their values.
- If load_en=0 (out_valid=1 and out_ready=0): out_data, out_chan and out_valid hold. All in_ready=0.
- Output transfer: out_valid && out_ready. A simultaneous output transfer and new input transfer in the same cycle is legal, giving full throughput of 1 word per cycle.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k.
- Round-robin pointer:
  - last <= c on every input transfer made in mode 1.
  - last is unchanged by mode-0 transfers and by idle cycles.
  - Wrap: after channel N-1 is granted, the search starts at channel 0.
- Mode or sel changes take effect on the next cycle's candidate computation. A word already held in the output register is unaffected.
- Only out_data, out_valid, out_chan and last are stored. No other state exists.
- Reset mid-operation: the held word is discarded and out_valid drops immediately (asynchronous). No in_ready is asserted while rst_n=0.
- Unselected channels are never consumed; their valid data waits with in_ready=0.

Test Plan (N=4, WIDTH=8):
- Reset and idle: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0x00 and out_chan=0 immediately. After release, with in_valid=0000: out_valid stays 0 and in_ready=0000.
- Mode 0 select: sel=2, in_valid=0100, ch2 data=0xA5, out_ready=1 -> in_ready=0100 and, one cycle later, out_data=0xA5, out_chan=2. Then set sel=3 with only ch2 valid -> in_ready=1000 and out_valid drops to 0.
- Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
- Round-robin skip and wrap: mode=1, last=1, in_valid=1001 -> grant ch3, then ch0, then ch3. Channels 1 and 2 are never granted.
- Backpressure: out_ready=0 while out_valid=1 holding 0x3C from ch1, for 3 cycles -> out_data=0x3C and out_chan=1 stable, in_ready=0000. On release, the next word follows with no bubble.
- Full throughput with simultaneous transfers: mode=0, sel=0, ch0 streams 0x01..0x05 with out_ready=1 -> 5 consecutive output words 0x01..0x05. in_ready[0]=1 every cycle.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: handshake bundle shared by stream_mux_rr and its environment.
//   mode      : 0 = external select, 1 = round-robin arbitration
//   sel       : channel select, used in mode 0 only
//   in_data   : N packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, driven by the mux)
//   out_data  : registered output word
//   out_valid : registered output valid
//   out_ready : downstream ready
//   out_chan  : channel index that produced out_data
// Modport "slave" is the mux side; modport "master" is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_chan;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel streaming multiplexer with a one-entry registered
// output stage. In mode 0 the channel is chosen by sel; in mode 1 a fair
// round-robin arbiter grants the next valid channel after the last grant.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : stream_mux_rr_if.slave (mode, sel, in_*, out_*)
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_rr_if.slave    bus
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  last_q,      last_d;

  logic             load_en;
  logic             cand_vld;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] cand_data;
  logic [N-1:0]     rdy;
  logic             xfer;

  // The output slot can take a word when empty or when it drains this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // Candidate selection. Round-robin searches last+1, last+2, ... modulo N.
  always_comb begin
    int idx;
    idx      = 0;
    cand_vld = 1'b0;
    cand     = '0;
    if (!bus.mode) begin
      // sel can exceed N-1 when N is not a power of two.
      if (int'(bus.sel) < N) begin
        cand_vld = 1'b1;
        cand     = bus.sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last_q) + k) % N;
        if (!cand_vld && bus.in_valid[idx]) begin
          cand_vld = 1'b1;
          cand     = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(cand) == i) cand_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // One-hot ready; rst_n gating keeps every ready low while reset is held.
  always_comb begin
    rdy = '0;
    if (rst_n && load_en && cand_vld) rdy[cand] = 1'b1;
  end

  assign xfer         = |(rdy & bus.in_valid);
  assign bus.in_ready = rdy;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (load_en) begin
      if (xfer) begin
        out_data_d  = cand_data;
        out_chan_d  = cand;
        out_valid_d = 1'b1;
        // Only arbitrated grants advance the fairness pointer.
        if (bus.mode) last_d = cand;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      // last = N-1 so channel 0 has first priority after reset.
      last_q      <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed bench for stream_mux_rr (N=4, WIDTH=8) with a
// behavioural reference model checked every cycle plus literal expectations.
module tb_stream_mux_rr;
  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  stream_mux_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

  stream_mux_rr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the word held at the output and the last RR grant.
  bit        m_valid;
  bit [7:0]  m_data;
  int        m_chan;
  int        m_last;

  // Channel the rules pick this cycle, or -1 when nothing is eligible.
  function automatic int model_cand();
    if (bus.mode == 1'b0) return (int'(bus.sel) < N) ? int'(bus.sel) : -1;
    for (int i = m_last + 1; i < N; i++) if (bus.in_valid[i]) return i;
    for (int i = 0; i <= m_last; i++) if (bus.in_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit [3:0] model_ready();
    int c;
    c = model_cand();
    if (rst_n !== 1'b1) return 4'b0000;
    if (m_valid && !bus.out_ready) return 4'b0000;
    if (c < 0) return 4'b0000;
    return 4'(1 << c);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int c;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_chan  <= 0;
      m_last  <= N - 1;
    end else if (!m_valid || bus.out_ready) begin
      c = model_cand();
      if (c >= 0 && bus.in_valid[c]) begin
        m_valid <= 1'b1;
        m_data  <= bus.in_data[c*WIDTH +: WIDTH];
        m_chan  <= c;
        if (bus.mode) m_last <= c;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.in_ready",  32'(bus.in_ready),  32'(model_ready()));
      chk("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model.out_data",  32'(bus.out_data),  32'(m_data));
      chk("model.out_chan",  32'(bus.out_chan),  32'(m_chan));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    bus.in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1;

    // Idle after reset: round-robin with nothing valid.
    bus.mode = 1'b1;
    tick();
    tick();
    chk("idle.out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle.in_ready",  32'(bus.in_ready),  32'b0000);

    // Mode 0 select of channel 2.
    bus.mode     = 1'b0;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    set_ch(2, 8'hA5);
    #1;
    chk("sel2.in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk("sel2.out_valid", 32'(bus.out_valid), 32'd1);
    chk("sel2.out_data",  32'(bus.out_data),  32'hA5);
    chk("sel2.out_chan",  32'(bus.out_chan),  32'd2);
    bus.sel = 2'd3;
    #1;
    chk("sel3.in_ready", 32'(bus.in_ready), 32'b1000);
    tick();
    chk("sel3.out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while a word is held.
    bus.sel = 2'd2;
    tick();
    chk("prerst.out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_data",  32'(bus.out_data),  32'h00);
    chk("rst.out_chan",  32'(bus.out_chan),  32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'b0000);
    tick();
    rst_n = 1'b1;

    // Round-robin fairness with all channels valid.
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr.out_valid", 32'(bus.out_valid), 32'd1);
      chk("rr.out_chan",  32'(bus.out_chan),  32'(i % 4));
      chk("rr.out_data",  32'(bus.out_data),  32'(8'h10 + (i % 4)));
    end

    // Move the pointer to 1, then skip 1 and 2 and wrap between 3 and 0.
    bus.in_valid = 4'b0010;
    tick();
    chk("rrset.out_chan", 32'(bus.out_chan), 32'd1);
    bus.in_valid = 4'b1001;
    tick();
    chk("wrap0.out_chan", 32'(bus.out_chan), 32'd3);
    tick();
    chk("wrap1.out_chan", 32'(bus.out_chan), 32'd0);
    tick();
    chk("wrap2.out_chan", 32'(bus.out_chan), 32'd3);

    // Backpressure while holding 0x3C from channel 1.
    bus.mode     = 1'b0;
    bus.sel      = 2'd1;
    bus.in_valid = 4'b0010;
    set_ch(1, 8'h3C);
    tick();
    chk("bp.load_data", 32'(bus.out_data), 32'h3C);
    bus.out_ready = 1'b0;
    set_ch(1, 8'h3D);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", 32'(bus.in_ready), 32'b0000);
      tick();
      chk("bp.out_data",  32'(bus.out_data),  32'h3C);
      chk("bp.out_chan",  32'(bus.out_chan),  32'd1);
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bprel.in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk("bprel.out_valid", 32'(bus.out_valid), 32'd1);
    chk("bprel.out_data",  32'(bus.out_data),  32'h3D);
    bus.in_valid = 4'b0000;
    tick();

    // Full throughput on channel 0.
    bus.sel = 2'd0;
    for (int v = 1; v <= 5; v++) begin
      set_ch(0, 8'(v));
      bus.in_valid = 4'b0001;
      #1;
      chk("thru.in_ready0", 32'(bus.in_ready[0]), 32'd1);
      tick();
      chk("thru.out_valid", 32'(bus.out_valid), 32'd1);
      chk("thru.out_data",  32'(bus.out_data),  32'(v));
    end
    bus.in_valid = 4'b0000;
    tick();
    chk("thru.drain", 32'(bus.out_valid), 32'd0);
    tick();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
